mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_master_if.sv | 30 +++
 rtl/mdio_master.sv | 190 +++++++++++++++++++
 tb/tb_mdio_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_master_if
//  Purpose  : Command/response bundle between a management host and the
//             MDIO master engine.
//  Revision : 1.0
// ============================================================================
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic        cmd_phyad_en;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_read, cmd_phyad_en, cmd_phyad, cmd_regad, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_phyad_en, cmd_phyad, cmd_regad, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_master
//  Purpose  : Clause-22 MDIO management master: one read or write frame
//             (preamble, header, turnaround, data, end bit) per command.
//  Revision : 1.0
// ============================================================================
module mdio_master #(
    parameter int         CLK_DIV     = 20,
    parameter logic [4:0] PHY_ADR_DEF = 5'h4
) (
    input  wire logic     ACLK,
    input  wire logic     ARESET,
    mdio_master_if.slave  cmd_if,
    output logic          MDC,
    output logic          MDIO_O,
    output logic          MDIO_OE,
    input  wire logic     MDIO_I
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_END  = 3'd5
    } state_t;

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_div_cnt;
    logic        r_mdc;
    logic [5:0]  r_bit_cnt;
    logic        r_read;
    logic [29:0] r_tx;
    logic [15:0] r_rx;
    logic        r_ta_err;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_bit_end;
    logic        w_sample;
    logic        w_last_bit;
    logic [5:0]  w_last_idx;
    logic [4:0]  w_phyad;

    assign w_accept  = cmd_if.cmd_valid && (r_state == S_IDLE);
    assign w_bit_end = (r_state != S_IDLE) && r_mdc && (r_div_cnt == c_DIV_LAST);
    assign w_sample  = (r_state != S_IDLE) && r_mdc && (r_div_cnt == 8'd0);
    assign w_phyad   = cmd_if.cmd_phyad_en ? cmd_if.cmd_phyad : PHY_ADR_DEF;

    always_comb begin
        w_last_idx = 6'd0;
        case (r_state)
            S_PRE:   w_last_idx = 6'd31;
            S_HDR:   w_last_idx = 6'd13;
            S_TA:    w_last_idx = 6'd1;
            S_DATA:  w_last_idx = 6'd15;
            default: w_last_idx = 6'd0;
        endcase
    end

    assign w_last_bit = (r_bit_cnt == w_last_idx);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the pad drive; pad values are pure functions of the
    // registered state, so they only move when a new bit period starts.
    always_comb begin
        w_state_nxt = r_state;
        MDIO_O      = 1'b1;
        MDIO_OE     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_if.cmd_valid) w_state_nxt = S_PRE;
            end
            S_PRE: begin
                MDIO_OE = 1'b1;
                if (w_bit_end && w_last_bit) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                MDIO_O  = r_tx[29];
                MDIO_OE = 1'b1;
                if (w_bit_end && w_last_bit) w_state_nxt = S_TA;
            end
            S_TA: begin
                if (!r_read) begin
                    MDIO_O  = (r_bit_cnt == 6'd0);
                    MDIO_OE = 1'b1;
                end
                if (w_bit_end && w_last_bit) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!r_read) begin
                    MDIO_O  = r_tx[29];
                    MDIO_OE = 1'b1;
                end
                if (w_bit_end && w_last_bit) w_state_nxt = S_END;
            end
            S_END: begin
                if (w_bit_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Half-period divider: r_mdc is the MDC level, toggled every CLK_DIV cycles.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_div_cnt <= 8'd0;
            r_mdc     <= 1'b0;
            r_bit_cnt <= 6'd0;
        end else if (w_accept) begin
            r_div_cnt <= 8'd0;
            r_mdc     <= 1'b0;
            r_bit_cnt <= 6'd0;
        end else if (r_state != S_IDLE) begin
            if (r_div_cnt == c_DIV_LAST) begin
                r_div_cnt <= 8'd0;
                r_mdc     <= ~r_mdc;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end
            if (w_bit_end) begin
                r_bit_cnt <= w_last_bit ? 6'd0 : r_bit_cnt + 6'd1;
            end
        end
    end

    // r_tx holds header then write data; it shifts only through HDR and DATA,
    // so write data is at the top of the register when DATA begins.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_read      <= 1'b0;
            r_tx        <= 30'd0;
            r_rx        <= 16'd0;
            r_ta_err    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_read   <= cmd_if.cmd_read;
                r_tx     <= {2'b01, (cmd_if.cmd_read ? 2'b10 : 2'b01), w_phyad,
                             cmd_if.cmd_regad, cmd_if.cmd_wdata};
                r_ta_err <= 1'b0;
            end
            if (w_bit_end && ((r_state == S_HDR) || (r_state == S_DATA))) begin
                r_tx <= {r_tx[28:0], 1'b0};
            end
            if (w_sample && r_read) begin
                if ((r_state == S_TA) && (r_bit_cnt == 6'd1)) begin
                    r_ta_err <= MDIO_I;
                end
                if (r_state == S_DATA) begin
                    r_rx <= {r_rx[14:0], MDIO_I};
                end
            end
            if (w_bit_end && (r_state == S_END)) begin
                r_rsp_valid <= 1'b1;
                if (r_read) begin
                    r_rsp_rdata <= r_rx;
                    r_rsp_err   <= r_ta_err;
                end else begin
                    r_rsp_err   <= 1'b0;
                end
            end
        end
    end

    assign MDC              = r_mdc;
    assign cmd_if.cmd_ready = (r_state == S_IDLE);
    assign cmd_if.rsp_valid = r_rsp_valid;
    assign cmd_if.rsp_rdata = r_rsp_rdata;
    assign cmd_if.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdio_master
//  Purpose  : Scoreboard bench for mdio_master with a behavioural PHY.
//  Revision : 1.0
// ============================================================================
module tb_mdio_master;
    localparam int D     = 2;
    localparam int FRAME = 130 * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic mdc, mdio_o, mdio_oe;
    logic mdio_i = 1'b1;

    mdio_master_if bus ();

    mdio_master #(.CLK_DIV(D), .PHY_ADR_DEF(5'h4)) dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .cmd_if  (bus),
        .MDC     (mdc),
        .MDIO_O  (mdio_o),
        .MDIO_OE (mdio_oe),
        .MDIO_I  (mdio_i)
    );

    typedef struct {
        bit          rd;
        int          mode;
        logic [15:0] pdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic [64:0] exp_o;
        logic [64:0] exp_oe;
        logic [64:0] care;
        int          rsp_cyc;
    } item_t;

    item_t sb[$];
    item_t cur;
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // PHY: mode 0 = absent (pull-up), 1 = proper TA z,0 then data,
    // 2 = drives data but leaves the second TA bit high.
    function automatic logic phy_bit(input int b);
        if (!cur.rd || cur.mode == 0) return 1'b1;
        if (b == 47) return (cur.mode == 1) ? 1'b0 : 1'b1;
        if (b >= 48 && b <= 63) return cur.pdata[63 - b];
        return 1'b1;
    endfunction

    // ---------------- monitor / PHY / scoreboard checker ----------------
    int          mA = 0;
    bit          active = 1'b0;
    int          cap_n = 0;
    logic [64:0] cap_o, cap_oe;
    int          shape_err = 0;
    int          idle_err  = 0;
    logic        prev_o, prev_oe;
    int          p, ph;
    item_t       got;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                mdio_i = 1'b1;
            end else begin
                p  = cyc - mA;
                ph = p % (2 * D);
                if (active && p < FRAME) begin
                    if (mdc !== (ph >= D)) shape_err++;
                    if (ph != 0 && (mdio_o !== prev_o || mdio_oe !== prev_oe)) shape_err++;
                    if (ph == D && cap_n < 65) begin
                        cap_o[64 - cap_n]  = mdio_o;
                        cap_oe[64 - cap_n] = mdio_oe;
                        cap_n++;
                    end
                    if (ph == 0) mdio_i = phy_bit(p / (2 * D));
                end else begin
                    if (mdc !== 1'b0 || mdio_oe !== 1'b0 || mdio_o !== 1'b1) idle_err++;
                    mdio_i = 1'b1;
                end
                if (bus.rsp_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        got = sb.pop_front();
                        chk("rsp_latency", cyc, got.rsp_cyc);
                        chk("rsp_rdata", bus.rsp_rdata, got.exp_rdata);
                        chk("rsp_err", bus.rsp_err, got.exp_err);
                        chk("frame_bits", cap_n, 65);
                        chk("mdio_o_stream", cap_o & got.care, got.exp_o & got.care);
                        chk("mdio_oe_stream", cap_oe, got.exp_oe);
                        chk("mdc_timing", shape_err, 0);
                    end
                    active = 1'b0;
                end
                if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
                    active    = 1'b1;
                    mA        = cyc + 1;
                    cap_n     = 0;
                    cap_o     = '0;
                    cap_oe    = '0;
                    shape_err = 0;
                    if (sb.size() > 0) cur = sb[sb.size() - 1];
                end
            end
            prev_o  = mdio_o;
            prev_oe = mdio_oe;
        end
    end

    // ---------------- stimulus ----------------
    int          last_A    = 0;
    bit          last_keep = 1'b0;
    logic [15:0] model_rdata = 16'h0;

    task automatic scramble();
        bus.cmd_read     = 1'($urandom);
        bus.cmd_phyad_en = 1'($urandom);
        bus.cmd_phyad    = 5'($urandom);
        bus.cmd_regad    = 5'($urandom);
        bus.cmd_wdata    = 16'($urandom);
    endtask

    task automatic issue(input bit rd, input bit pen, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd,
                         input int mode, input logic [15:0] pd, input bit keep);
        item_t      it;
        int         waited;
        int         A;
        logic [4:0] pa_eff;
        bus.cmd_read     = rd;
        bus.cmd_phyad_en = pen;
        bus.cmd_phyad    = pa;
        bus.cmd_regad    = ra;
        bus.cmd_wdata    = wd;
        bus.cmd_valid    = 1'b1;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 4 * FRAME) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got cmd_ready=%b expected 1 (cycle %0d)", bus.cmd_ready, cyc);
            bus.cmd_valid = 1'b0;
            last_keep     = 1'b0;
            return;
        end
        A = cyc + 1;
        if (last_keep) chk("b2b_accept_cycle", A, last_A + FRAME + 1);
        pa_eff    = pen ? pa : 5'h4;
        it.rd     = rd;
        it.mode   = mode;
        it.pdata  = pd;
        it.exp_o  = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), pa_eff, ra,
                     (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wd), 1'b1};
        it.exp_oe = {{46{1'b1}}, (rd ? 18'h0 : {18{1'b1}}), 1'b0};
        it.care   = it.exp_oe | 65'h1;
        if (rd) begin
            it.exp_rdata = (mode == 0) ? 16'hFFFF : pd;
            it.exp_err   = (mode != 1);
            model_rdata  = it.exp_rdata;
        end else begin
            it.exp_rdata = model_rdata;
            it.exp_err   = 1'b0;
        end
        it.rsp_cyc = A + FRAME;
        sb.push_back(it);
        last_A    = A;
        last_keep = keep;
        @(posedge clk); #1;
        scramble();
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    int waited_end;

    initial begin
        bus.cmd_valid = 1'b0;
        scramble();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_cmd_ready", bus.cmd_ready, 1'b1);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 16'h0);
        chk("reset_rsp_err", bus.rsp_err, 1'b0);
        chk("reset_pins", {mdc, mdio_o, mdio_oe}, 3'b010);
        @(posedge clk); #1;

        issue(1'b0, 1'b1, 5'd4, 5'd0, 16'h1140, 0, 16'h0, 1'b0);
        issue(1'b1, 1'b0, 5'd17, 5'd1, 16'hA5A5, 1, 16'h796D, 1'b0);
        issue(1'b1, 1'b1, 5'd9, 5'd2, 16'h0000, 0, 16'h1234, 1'b0);

        // back-to-back with cmd_valid held high and busy-time garbage on cmd_*
        issue(1'b0, 1'b1, 5'd3, 5'd7, 16'hBEEF, 0, 16'h0, 1'b1);
        issue(1'b1, 1'b1, 5'd30, 5'd31, 16'h0, 2, 16'hC3A1, 1'b1);
        issue(1'b0, 1'b0, 5'd0, 5'd16, 16'h8001, 0, 16'h0, 1'b0);

        // reset in the middle of bit 40 of a write, command presented during reset
        issue(1'b0, 1'b1, 5'd12, 5'd5, 16'h5A5A, 0, 16'h0, 1'b0);
        repeat (40 * 2 * D) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        void'(sb.pop_back());
        model_rdata = 16'h0;
        last_keep   = 1'b0;
        @(posedge clk); #1;
        chk("abort_mdc", mdc, 1'b0);
        chk("abort_oe", mdio_oe, 1'b0);
        chk("abort_no_rsp", bus.rsp_valid, 1'b0);
        chk("abort_rdata_cleared", bus.rsp_rdata, 16'h0);
        chk("abort_not_accepted", bus.cmd_ready, 1'b1);
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        issue(1'b1, 1'b1, 5'd6, 5'd3, 16'h0, 1, 16'h0F0F, 1'b0);

        for (int i = 0; i < 14; i++) begin
            issue(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                  int'($urandom_range(0, 2)), 16'($urandom),
                  (i < 13) ? 1'($urandom) : 1'b0);
        end

        waited_end = 0;
        while (sb.size() != 0 && waited_end < 4 * FRAME) begin
            @(posedge clk);
            waited_end++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got %0d pending responses expected 0", sb.size());
        end
        repeat (4) @(posedge clk);
        #1;
        chk("idle_outputs", idle_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
